// File: rtl/regfile_xfer_engine_if.sv
// regfile_xfer_engine_if: command, register-file and stream signals of the transfer engine
interface regfile_xfer_engine_if #(parameter int AW = 5, parameter int DW = 32);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_start;
  logic [AW:0]   cmd_count;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          busy;
  logic          done;
  modport master (
    input  cmd_valid, cmd_op, cmd_start, cmd_count, rf_rdata, out_ready, in_valid, in_data,
    output cmd_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, out_valid, out_data, out_addr,
           in_ready, busy, done
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_start, cmd_count, rf_rdata, out_ready, in_valid, in_data,
    input  cmd_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, out_valid, out_data, out_addr,
           in_ready, busy, done
  );
endinterface

// File: rtl/regfile_xfer_engine.sv
// regfile_xfer_engine: bulk dump/load of a register file range over valid/ready streams
module regfile_xfer_engine #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic clk,
  input logic reset,
  regfile_xfer_engine_if.master bus
);
  typedef enum logic [1:0] {IDLE, DUMP, LOAD, FINISH} state_t;
  localparam logic [AW:0] NR = (AW+1)'(NREGS);
  state_t        state, state_n;
  logic [AW-1:0] addr;
  logic [AW:0]   rem;
  logic          ov;
  logic [DW-1:0] od;
  logic [AW-1:0] oa;
  logic          adv, we, in_rdy;
  assign in_rdy = state == LOAD && rem != '0 && !reset;
  assign we     = in_rdy && bus.in_valid;
  assign adv    = state == DUMP && (!ov || bus.out_ready) && rem != '0;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.cmd_valid ? (bus.cmd_op ? LOAD : DUMP) : IDLE)
            : state == DUMP ? ((rem == '0 && (!ov || bus.out_ready)) ? FINISH : DUMP)
            : state == LOAD ? ((rem == '0 || (we && rem == (AW+1)'(1))) ? FINISH : LOAD)
            : IDLE;
  end
  // the output register refills in the same cycle it handshakes, giving one word per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      rem  <= '0;
      ov   <= 1'b0;
      od   <= '0;
      oa   <= '0;
    end else if (state == IDLE && bus.cmd_valid) begin
      addr <= bus.cmd_start;
      rem  <= bus.cmd_count > NR ? NR : bus.cmd_count;
    end else begin
      if (adv || we) begin
        addr <= addr + AW'(1);
        rem  <= rem - (AW+1)'(1);
      end
      if (adv) begin
        ov <= 1'b1;
        od <= bus.rf_rdata;
        oa <= addr;
      end else if (ov && bus.out_ready) begin
        ov <= 1'b0;
      end
    end
  end
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == FINISH;
  assign bus.rf_raddr  = addr;
  assign bus.rf_we     = we;
  assign bus.rf_waddr  = addr;
  assign bus.rf_wdata  = we ? bus.in_data : '0;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_addr  = oa;
endmodule

// File: tb/tb_regfile_xfer_engine.sv
// tb_regfile_xfer_engine: directed checks of dump/load, backpressure, wrap, edge counts and abort
module tb_regfile_xfer_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rf_clr = 1'b1;
  always #5 clk = ~clk;
  regfile_xfer_engine_if #(.AW(5), .DW(32)) bus();
  regfile_xfer_engine #(.NREGS(32), .AW(5), .DW(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] rf [32];
  logic [31:0] exp_mem [32];
  int n_assert = 0;
  int n_fail = 0;
  assign bus.rf_rdata = rf[bus.rf_raddr];
  // register file with hardwired x0
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.rf_we && bus.rf_waddr != 5'd0) begin
      rf[bus.rf_waddr] <= bus.rf_wdata;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic cmd(input logic op, input logic [4:0] st, input logic [5:0] cnt);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_start = st;
    bus.cmd_count = cnt;
    step();
    bus.cmd_valid = 1'b0;
    #1;
    chk("busy_after_accept", bus.busy, 1);
    chk("cmd_ready_while_busy", bus.cmd_ready, 0);
  endtask
  task automatic load_seq(input logic [4:0] st, input logic [5:0] cnt, input int nw,
                          input logic [31:0] first, input logic [31:0] stp);
    logic [4:0] a;
    bus.in_valid = 1'b1;
    bus.in_data  = first;
    cmd(1'b1, st, cnt);
    if (nw == 0) begin
      chk("load0_in_ready", bus.in_ready, 0);
      chk("load0_we", bus.rf_we, 0);
      step();
    end
    for (int i = 0; i < nw; i++) begin
      a = st + 5'(i);
      bus.in_data = first + 32'(i) * stp;
      #1;
      chk("load_we", bus.rf_we, 1);
      chk("load_waddr", bus.rf_waddr, a);
      chk("load_wdata", bus.rf_wdata, bus.in_data);
      if (a != 5'd0) exp_mem[a] = bus.in_data;
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("load_done", bus.done, 1);
    chk("load_finish_busy", bus.busy, 1);
    chk("load_finish_we", bus.rf_we, 0);
    step();
    chk("load_done_pulse", bus.done, 0);
    chk("load_idle", bus.cmd_ready, 1);
  endtask
  task automatic dump_seq(input logic [4:0] st, input logic [5:0] cnt, input int nw);
    logic [4:0] a;
    bus.out_ready = 1'b1;
    cmd(1'b0, st, cnt);
    chk("dump_first_valid_latency", bus.out_valid, 0);
    step();
    for (int i = 0; i < nw; i++) begin
      a = st + 5'(i);
      chk("dump_valid", bus.out_valid, 1);
      chk("dump_addr", bus.out_addr, a);
      chk("dump_data", bus.out_data, exp_mem[a]);
      step();
    end
    chk("dump_done", bus.done, 1);
    chk("dump_finish_valid", bus.out_valid, 0);
    step();
    chk("dump_done_pulse", bus.done, 0);
    chk("dump_idle_busy", bus.busy, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic pv, pr;
    logic [31:0] pd;
    logic [4:0] pa;
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_start = '0; bus.cmd_count = '0;
    bus.out_ready = 0; bus.in_valid = 0; bus.in_data = '0;
    step();
    step();
    reset  = 1'b0;
    rf_clr = 1'b0;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_data", bus.out_data, 0);
    step();
    load_seq(5'd1, 6'd4, 4, 32'h11, 32'h11);
    dump_seq(5'd1, 6'd4, 4);
    // out_ready pattern 1,0,0 repeating; stalled words must hold
    bus.out_ready = 1'b1;
    cmd(1'b0, 5'd0, 6'd3);
    n = 0; pv = 0; pr = 0; pd = '0; pa = '0;
    for (int c = 0; c < 40 && !bus.done; c++) begin
      bus.out_ready = (c % 3 == 0);
      #1;
      if (pv && !pr) begin
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_data", bus.out_data, pd);
        chk("bp_hold_addr", bus.out_addr, pa);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_addr", bus.out_addr, n);
        chk("bp_data", bus.out_data, exp_mem[n]);
        n++;
      end
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pa = bus.out_addr;
      step();
    end
    chk("bp_done", bus.done, 1);
    chk("bp_handshakes", n, 3);
    step();
    load_seq(5'd30, 6'd4, 4, 32'hA, 32'h1);
    chk("x0_stays_zero", rf[0], 0);
    dump_seq(5'd30, 6'd4, 4);
    dump_seq(5'd7, 6'd0, 0);
    load_seq(5'd7, 6'd0, 0, 32'h77, 32'h1);
    dump_seq(5'd0, 6'd40, 32);
    bus.in_valid = 1'b1;
    cmd(1'b1, 5'd10, 6'd5);
    for (int i = 0; i < 2; i++) begin
      bus.in_data = 32'h51 + 32'(i);
      #1;
      chk("abort_we", bus.rf_we, 1);
      exp_mem[10 + i] = bus.in_data;
      step();
    end
    reset = 1'b1;
    bus.in_data = 32'h53;
    #1;
    chk("abort_no_write_in_reset", bus.rf_we, 0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_we_idle", bus.rf_we, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    dump_seq(5'd10, 6'd3, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_xfer_engine.md
Name: regfile_xfer_engine

Overview:
Bulk-access initiator for the CPU's 32x32 register file, used for debug snapshot and context restore. On a command it either sweeps a range of register addresses and streams the values out (DUMP), or writes a range of registers from an input stream (LOAD). It drives the register file's read-address and write ports. While busy is high, the core stalls so that no other agent touches those ports.

Parameters:
NREGS, 32, number of architectural registers; must be a power of two.
AW, 5, register address width (log2 NREGS).
DW, 32, register data width.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  high only in IDLE.
cmd_op  input  1  0 = DUMP, 1 = LOAD.
cmd_start  input  AW  first register address.
cmd_count  input  AW+1  number of registers to transfer.
rf_raddr  output  AW  to register file read port (combinational read).
rf_rdata  input  DW  read value returned for rf_raddr, same cycle.
rf_we  output  1  register file write enable.
rf_waddr  output  AW  register file write address.
rf_wdata  output  DW  register file write data.
out_valid  output  1  DUMP stream valid.
out_ready  input  1  DUMP stream ready.
out_data  output  DW  dumped register value.
out_addr  output  AW  address of out_data.
in_valid  input  1  LOAD stream valid.
in_ready  output  1  LOAD stream ready.
in_data  input  DW  value to write.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when a command completes.

Behaviour:
- States: IDLE, DUMP, LOAD, FINISH.
- Reset values: state IDLE; all outputs 0 except cmd_ready = 1. Reset in any state aborts the command immediately. Pending out data is discarded and no write is issued in the reset cycle.
- Command acceptance: a command is accepted on cmd_valid && cmd_ready. The engine latches op, addr = cmd_start, and remaining = min(cmd_count, NREGS); values above NREGS saturate to NREGS.
- Zero count: cmd_count = 0 goes straight to FINISH with no transfers.
- Address wrap: the address increments modulo NREGS, e.g. start 30, count 4 gives 30, 31, 0, 1.
- DUMP datapath: rf_raddr = addr. The output register holds {out_data, out_addr, out_valid}. When out_valid = 0 or out_ready = 1, and remaining > 0, the engine captures rf_rdata/addr into the output register, sets out_valid, increments addr and decrements remaining.
- DUMP output rules:
  - out_data and out_addr must stay stable while out_valid && !out_ready.
  - Throughput is one word per cycle with out_ready held high.
  - First out_valid appears 2 cycles after the accept edge.
- DUMP exit: leave DUMP for FINISH once remaining = 0 and the last word has handshaken (out_valid && out_ready).
- LOAD datapath: in_ready = 1 in LOAD while remaining > 0. rf_we = in_valid && in_ready, with rf_waddr = addr and rf_wdata = in_data driven combinationally. The write lands at that clock edge, and addr/remaining advance on it. Outside LOAD, rf_we = 0.
- LOAD exit: after the last write, go to FINISH.
- Address 0: writes to address 0 are still issued; the register file keeps x0 = 0. A dump of x0 returns 0.
- FINISH: lasts exactly one cycle with done = 1 and busy = 1, then returns to IDLE.
- IDLE: cmd_valid in IDLE is ignored only when cmd_ready = 0, which cannot occur in IDLE.
- Stream isolation: in_valid outside LOAD is not consumed. out_ready outside DUMP is ignored.
- busy is registered and is 1 from the cycle after accept through FINISH inclusive.

Test Plan:
- Reset check: assert reset 2 cycles, then release -> cmd_ready = 1; busy, done, rf_we, out_valid and in_ready all 0.
- LOAD x1..x4: LOAD start 1 count 4, in_data 0x11, 0x22, 0x33, 0x44 with in_valid held high -> rf_we high for 4 consecutive cycles at addresses 1..4. Then DUMP start 1 count 4 with out_ready = 1 -> out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles; done pulse follows, then IDLE.
- Backpressure: DUMP start 0 count 3 with out_ready toggling 1, 0, 0, 1, ... -> each word held stable while stalled; exactly 3 handshakes with out_addr 0, 1, 2; no word duplicated or lost.
- Wrap and x0: LOAD start 30 count 4 with 0xA, 0xB, 0xC, 0xD -> writes at 30, 31, 0, 1. A following dump returns x0 = 0 and x1 = 0xD.
- Edge counts: count 0 -> done pulse 2 cycles after accept with no rf_we or out_valid. Count 40 -> exactly 32 transfers.
- Reset mid-op: assert reset during LOAD after 2 of 5 words -> next cycle IDLE with all outputs at reset values; only the first 2 registers were written.
